alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised multi-cycle successor to the single-op combinational MIPS ALU used in the CPU datapath.
- Decodes R-type instruction words (opcode 6'b000000) and executes shifts, add/sub, logic and set-less-than operations.
- Shifts are performed iteratively, STEP bits per cycle; all other operations complete in one cycle.
- Uses a start/busy/done handshake and produces registered zero/neg/overflow/illegal flags for the control unit.

Parameters:
- WIDTH, 32, datapath width; legal values 32 or 64.
- STEP, 1, bits shifted per SHIFT cycle; power of two, 1..WIDTH.
- SHAMT_W, $clog2(WIDTH), derived; width of the variable shift amount.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- i_datain  input  32  instruction word: opcode = [31:26], shamt = [10:6], funct = [5:0].
- gr1  input  WIDTH  operand A (the shifted value for all shifts).
- gr2  input  WIDTH  operand B; for variable shifts the amount is gr2[SHAMT_W-1:0].
- c  output  WIDTH  registered result; held until the next completed operation.
- busy  output  1  high while the FSM is in SHIFT.
- done  output  1  one-cycle completion pulse.
- zero  output  1  c == 0; updated together with c.
- neg  output  1  c[WIDTH-1]; updated together with c.
- overflow  output  1  signed overflow of add/sub.
- illegal  output  1  last accepted op was unsupported.

Behaviour:
- Reset: state IDLE; c, done, busy, zero, neg, overflow, illegal all 0.
- Reset mid-shift aborts the operation; no done pulse is produced.
- Operands and i_datain are captured when start=1 is sampled in IDLE; inputs may change afterwards.
- Supported funct codes (opcode 000000):
  - 000000 sll, 000010 srl, 000011 sra: amount = shamt, zero-extended.
  - 000100 sllv, 000110 srlv, 000111 srav: amount = gr2[SHAMT_W-1:0].
  - 100000 add, 100001 addu, 100010 sub, 100011 subu.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt (signed), 101011 sltu: result is 1 or 0, zero-extended.
- Any other opcode/funct: illegal=1, overflow=0, c/zero/neg hold, done pulses in cycle 1.
- States: IDLE, SHIFT.
  - IDLE + start + non-shift, or shift with amount 0 → result registered, done=1 next cycle, stay IDLE.
  - IDLE + start + shift with amount > 0 → load accumulator and remaining count, go to SHIFT.
  - SHIFT: each cycle shift by min(STEP, remaining) and decrement remaining.
  - On the step that makes remaining = 0: write c and flags, done=1, go to IDLE.
- Timing, with start in cycle 0 and k = ceil(amount/STEP) (k = 0 for non-shifts and zero-amount shifts):
  - busy is high in cycles 1..k.
  - done and the new c are valid in cycle k+1, with busy low.
- Back-to-back:
  - start in a done cycle is accepted.
  - Non-shift ops may be issued every cycle, giving done every cycle.
  - start while busy is ignored; no queuing.
- Arithmetic:
  - sra/srav fill with the original gr1[WIDTH-1] on every step.
  - srl fills with 0.
  - add/sub/slt/sltu are modulo 2^WIDTH.
- Overflow: set only for add/sub when operand signs make the result sign wrong; 0 for every other op, including addu/subu.
- illegal is cleared by the next legal accepted op.
- done is never high for two consecutive cycles from one operation.

Test Plan:
- Reset, then sll with gr1=32'h0000_0001, shamt=4, STEP=1 → busy cycles 1-4; done in cycle 5; c=32'h10; zero=0; neg=0.
- sra with gr1=32'h8000_0000, shamt=31, STEP=4 → done in cycle 9 (k=8); c=32'hFFFF_FFFF; neg=1.
- add 32'h7FFF_FFFF + 1 → done in cycle 1; c=32'h8000_0000; overflow=1. Then addu with the same operands → overflow=0.
- Back-to-back: sub 5-5 then slt (-1 < 1) on consecutive cycles → done cycles 1 and 2; c=0 with zero=1, then c=1. A start issued mid-srlv (gr2=8) is ignored.
- Illegal funct 6'b111111 → done cycle 1, illegal=1, c unchanged. Next legal op clears illegal.
- reset asserted during an srlv with amount 20 → no done; outputs return to 0. WIDTH=64 sllv with amount 40 → c=gr1<<40.

Source files
------------

// File: rtl/alu_iter.sv
// Multi-cycle R-type ALU. Shifts run iteratively, STEP bits per cycle. All other ops
// finish in one cycle.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   start             - request, sampled only while idle
//   i_datain          - instruction word (opcode [31:26], shamt [10:6], funct [5:0])
//   gr1, gr2          - operands; gr1 is the shifted value, gr2 gives variable shift amounts
//   c                 - registered result, held until the next completed operation
//   busy, done        - busy while shifting; done pulses for one cycle on completion
//   zero, neg         - flags of c, updated together with c
//   overflow, illegal - signed add/sub overflow; last accepted op was unsupported
module alu_iter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 1,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      i_datain,
  input  logic [WIDTH-1:0] gr1,
  input  logic [WIDTH-1:0] gr2,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             neg,
  output logic             overflow,
  output logic             illegal
);

  // One extra bit so that STEP == WIDTH is representable.
  localparam logic [SHAMT_W:0] StepAmt = (SHAMT_W+1)'(STEP);

  typedef enum logic [0:0] {StIdle, StShift} state_e;
  typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

  state_e             state_q, state_d;
  shift_e             kind_q, kind_d;
  logic [WIDTH-1:0]   acc_q, acc_d, c_q, c_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               done_q, done_d, zero_q, zero_d, neg_q, neg_d;
  logic               ovf_q, ovf_d, ill_q, ill_d;

  logic [5:0] opcode, funct;
  logic [4:0] shamt;
  logic       unused_instr;

  assign opcode       = i_datain[31:26];
  assign shamt        = i_datain[10:6];
  assign funct        = i_datain[5:0];
  assign unused_instr = ^i_datain[25:11];

  // Decode and single-cycle result
  logic               dec_legal, dec_shift, dec_var, dec_ovf;
  shift_e             dec_kind;
  logic [WIDTH-1:0]   dec_res, sum, diff;
  logic [SHAMT_W-1:0] dec_amt;

  assign sum  = gr1 + gr2;
  assign diff = gr1 - gr2;

  always_comb begin
    dec_legal = 1'b0;
    dec_shift = 1'b0;
    dec_var   = 1'b0;
    dec_kind  = ShSll;
    dec_res   = '0;
    dec_ovf   = 1'b0;
    if (opcode == 6'b000000) begin
      dec_legal = 1'b1;
      case (funct)
        // A zero-amount shift completes immediately with gr1 as the result.
        6'b000000, 6'b000100: begin
          dec_shift = 1'b1; dec_kind = ShSll; dec_var = funct[2]; dec_res = gr1;
        end
        6'b000010, 6'b000110: begin
          dec_shift = 1'b1; dec_kind = ShSrl; dec_var = funct[2]; dec_res = gr1;
        end
        6'b000011, 6'b000111: begin
          dec_shift = 1'b1; dec_kind = ShSra; dec_var = funct[2]; dec_res = gr1;
        end
        6'b100000: begin
          dec_res = sum;
          dec_ovf = (gr1[WIDTH-1] == gr2[WIDTH-1]) && (sum[WIDTH-1] != gr1[WIDTH-1]);
        end
        6'b100001: dec_res = sum;
        6'b100010: begin
          dec_res = diff;
          dec_ovf = (gr1[WIDTH-1] != gr2[WIDTH-1]) && (diff[WIDTH-1] != gr1[WIDTH-1]);
        end
        6'b100011: dec_res = diff;
        6'b100100: dec_res = gr1 & gr2;
        6'b100101: dec_res = gr1 | gr2;
        6'b100110: dec_res = gr1 ^ gr2;
        6'b100111: dec_res = ~(gr1 | gr2);
        6'b101010: dec_res = WIDTH'($signed(gr1) < $signed(gr2));
        6'b101011: dec_res = WIDTH'(gr1 < gr2);
        default:   dec_legal = 1'b0;
      endcase
    end
  end

  assign dec_amt = dec_var ? gr2[SHAMT_W-1:0] : SHAMT_W'(shamt);

  // Iterative shift step: min(STEP, remaining)
  logic [SHAMT_W:0] rem_ext, step_amt, rem_left;
  logic [WIDTH-1:0] shifted;
  logic             last_step;

  assign rem_ext   = {1'b0, rem_q};
  assign step_amt  = (rem_ext < StepAmt) ? rem_ext : StepAmt;
  assign rem_left  = rem_ext - step_amt;
  assign last_step = (rem_left == '0);

  // Arithmetic shift of the accumulator keeps re-filling with the original sign bit.
  always_comb begin
    case (kind_q)
      ShSll:   shifted = acc_q << step_amt;
      ShSrl:   shifted = acc_q >> step_amt;
      ShSra:   shifted = WIDTH'($signed(acc_q) >>> step_amt);
      default: shifted = acc_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start && dec_legal && dec_shift && (dec_amt != '0)) state_d = StShift;
      StShift: if (last_step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == StShift);
  end

  // Datapath next state
  always_comb begin
    c_d    = c_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    ill_d  = ill_q;
    acc_d  = acc_q;
    rem_d  = rem_q;
    kind_d = kind_q;
    done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (!dec_legal) begin
            ill_d  = 1'b1;
            ovf_d  = 1'b0;
            done_d = 1'b1;
          end else if (dec_shift && (dec_amt != '0)) begin
            acc_d  = gr1;
            rem_d  = dec_amt;
            kind_d = dec_kind;
          end else begin
            c_d    = dec_res;
            zero_d = (dec_res == '0);
            neg_d  = dec_res[WIDTH-1];
            ovf_d  = dec_ovf;
            ill_d  = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      StShift: begin
        acc_d = shifted;
        rem_d = rem_left[SHAMT_W-1:0];
        if (last_step) begin
          c_d    = shifted;
          zero_d = (shifted == '0);
          neg_d  = shifted[WIDTH-1];
          ovf_d  = 1'b0;
          ill_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q    <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
      done_q <= 1'b0;
      acc_q  <= '0;
      rem_q  <= '0;
      kind_q <= ShSll;
    end else begin
      c_q    <= c_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
      ill_q  <= ill_d;
      done_q <= done_d;
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      kind_q <= kind_d;
    end
  end

  assign c        = c_q;
  assign done     = done_q;
  assign zero     = zero_q;
  assign neg      = neg_q;
  assign overflow = ovf_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: three instances (32/STEP1, 32/STEP4, 64/STEP8) share one stimulus
// stream and are each compared cycle by cycle against an arithmetic reference model.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] i_datain;
  logic [63:0] gr1, gr2;
  logic [31:0] c_a, c_b;
  logic [63:0] c_c;
  logic [2:0]  busy_o, done_o, zero_o, neg_o, ovf_o, ill_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32), .STEP(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .i_datain(i_datain),
    .gr1(gr1[31:0]), .gr2(gr2[31:0]), .c(c_a), .busy(busy_o[0]), .done(done_o[0]),
    .zero(zero_o[0]), .neg(neg_o[0]), .overflow(ovf_o[0]), .illegal(ill_o[0])
  );

  alu_iter #(.WIDTH(32), .STEP(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .i_datain(i_datain),
    .gr1(gr1[31:0]), .gr2(gr2[31:0]), .c(c_b), .busy(busy_o[1]), .done(done_o[1]),
    .zero(zero_o[1]), .neg(neg_o[1]), .overflow(ovf_o[1]), .illegal(ill_o[1])
  );

  alu_iter #(.WIDTH(64), .STEP(8)) u_dut_c (
    .clk(clk), .reset(reset), .start(start), .i_datain(i_datain),
    .gr1(gr1), .gr2(gr2), .c(c_c), .busy(busy_o[2]), .done(done_o[2]),
    .zero(zero_o[2]), .neg(neg_o[2]), .overflow(ovf_o[2]), .illegal(ill_o[2])
  );

  typedef struct packed {
    logic        legal;
    logic [6:0]  k;
    logic [63:0] c;
    logic        ovf;
  } mres_t;

  // Architectural state expected of each instance
  logic [63:0] m_c [3];
  logic [2:0]  m_z, m_n, m_o, m_i;
  logic [5:0]  funct_tab [18];

  function automatic int wof(input int d);
    return (d == 2) ? 64 : 32;
  endfunction

  function automatic int sof(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
  endfunction

  function automatic logic [63:0] obs_c(input int d);
    case (d)
      0:       return {32'b0, c_a};
      1:       return {32'b0, c_b};
      default: return c_c;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {op, 15'($urandom), sh, fn};
  endfunction

  // Reference: whole-operation result and latency from plain arithmetic.
  function automatic mres_t model(input logic [31:0] ins, input logic [63:0] a_in, b_in,
                                  input int w, input int s);
    mres_t       r;
    logic [63:0] mask, a, b, sa, sb;
    int          amt;
    logic        shift;
    mask  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    a     = a_in & mask;
    b     = b_in & mask;
    sa    = (w == 32) ? {{32{a[31]}}, a[31:0]} : a;
    sb    = (w == 32) ? {{32{b[31]}}, b[31:0]} : b;
    r     = '0;
    r.legal = 1'b1;
    shift = 1'b0;
    amt   = 0;
    if (ins[31:26] != 6'd0) begin
      r.legal = 1'b0;
    end else begin
      case (ins[5:0])
        6'b000000: begin shift = 1; amt = int'(ins[10:6]); r.c = a << amt; end
        6'b000010: begin shift = 1; amt = int'(ins[10:6]); r.c = a >> amt; end
        6'b000011: begin shift = 1; amt = int'(ins[10:6]); r.c = $signed(sa) >>> amt; end
        6'b000100: begin shift = 1; amt = int'(b % 64'(w)); r.c = a << amt; end
        6'b000110: begin shift = 1; amt = int'(b % 64'(w)); r.c = a >> amt; end
        6'b000111: begin shift = 1; amt = int'(b % 64'(w)); r.c = $signed(sa) >>> amt; end
        6'b100000, 6'b100001: begin
          r.c = (a + b) & mask;
          if (!ins[0]) r.ovf = (a[w-1] == b[w-1]) && (r.c[w-1] != a[w-1]);
        end
        6'b100010, 6'b100011: begin
          r.c = (a - b) & mask;
          if (!ins[0]) r.ovf = (a[w-1] != b[w-1]) && (r.c[w-1] != a[w-1]);
        end
        6'b100100: r.c = a & b;
        6'b100101: r.c = a | b;
        6'b100110: r.c = a ^ b;
        6'b100111: r.c = ~(a | b);
        6'b101010: r.c = {63'b0, ($signed(sa) < $signed(sb))};
        6'b101011: r.c = {63'b0, (a < b)};
        default:   r.legal = 1'b0;
      endcase
    end
    r.c = r.c & mask;
    if (shift) r.k = 7'((amt + s - 1) / s);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Flags packed as {busy, done, zero, neg, overflow, illegal}.
  task automatic check_dut(input string name, input int d, input int cyc,
                           input logic eb, input logic ed);
    check($sformatf("%s.d%0d.cy%0d.c", name, d, cyc), obs_c(d), m_c[d]);
    check($sformatf("%s.d%0d.cy%0d.flags", name, d, cyc),
          64'({busy_o[d], done_o[d], zero_o[d], neg_o[d], ovf_o[d], ill_o[d]}),
          64'({eb, ed, m_z[d], m_n[d], m_o[d], m_i[d]}));
  endtask

  task automatic commit(input int d, input mres_t r);
    if (r.legal) begin
      m_c[d] = r.c;
      m_z[d] = (r.c == 64'd0);
      m_n[d] = r.c[wof(d)-1];
      m_o[d] = r.ovf;
      m_i[d] = 1'b0;
    end else begin
      m_o[d] = 1'b0;
      m_i[d] = 1'b1;
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) m_c[d] = '0;
    m_z = '0; m_n = '0; m_o = '0; m_i = '0;
  endtask

  // Issue op1 in cycle 0 and optionally op2 in cycle 1, then check every instance every
  // cycle until each has been quiet for a cycle after its last done. Called at a negedge.
  task automatic run(input string name, input logic [31:0] i1, input logic [63:0] a1, b1,
                     input logic two, input logic [31:0] i2, input logic [63:0] a2, b2);
    mres_t r1 [3];
    mres_t r2 [3];
    int    d1 [3];
    int    d2 [3];
    int    last;
    logic  eb, ed;
    last = 0;
    for (int d = 0; d < 3; d++) begin
      r1[d] = model(i1, a1, b1, wof(d), sof(d));
      r2[d] = model(i2, a2, b2, wof(d), sof(d));
      d1[d] = int'(r1[d].k) + 1;
      d2[d] = (two && r1[d].k == 0) ? int'(r2[d].k) + 2 : 0;
      if (d1[d] > last) last = d1[d];
      if (d2[d] > last) last = d2[d];
    end
    last = last + 1;
    start = 1'b1; i_datain = i1; gr1 = a1; gr2 = b1;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        eb = (cyc <= int'(r1[d].k)) || (d2[d] != 0 && cyc >= 2 && cyc < d2[d]);
        ed = (cyc == d1[d]) || (d2[d] != 0 && cyc == d2[d]);
        if (cyc == d1[d]) commit(d, r1[d]);
        if (d2[d] != 0 && cyc == d2[d]) commit(d, r2[d]);
        check_dut(name, d, cyc, eb, ed);
      end
      if (cyc == 1 && two) begin
        start = 1'b1; i_datain = i2; gr1 = a2; gr2 = b2;
      end else begin
        start = 1'b0; i_datain = $urandom; gr1 = {$urandom, $urandom};
        gr2 = {$urandom, $urandom};
      end
    end
  endtask

  initial begin
    logic [5:0]  op, fn;
    logic [63:0] ra, rb;
    funct_tab = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                  6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                  6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b100000, 6'b000111};
    reset = 1'b1; start = 1'b0; i_datain = '0; gr1 = '0; gr2 = '0;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) check_dut("reset", d, 0, 1'b0, 1'b0);

    run("sll4", mk(6'd0, 5'd4, 6'b000000), 64'h1, 64'h0, 1'b0, 32'h0, 64'h0, 64'h0);
    check("sll4_lit", obs_c(0), 64'h10);

    run("sra31", mk(6'd0, 5'd31, 6'b000011), 64'h8000_0000, 64'h5, 1'b0, 32'h0, 64'h0, 64'h0);
    check("sra31_lit", obs_c(1), 64'hFFFF_FFFF);

    run("add_ovf", mk(6'd0, 5'd0, 6'b100000), 64'h7FFF_FFFF, 64'h1, 1'b0, 32'h0, 64'h0, 64'h0);
    check("add_ovf_lit", 64'(ovf_o[0]), 64'h1);
    run("addu", mk(6'd0, 5'd0, 6'b100001), 64'h7FFF_FFFF, 64'h1, 1'b0, 32'h0, 64'h0, 64'h0);
    check("addu_lit", 64'(ovf_o[0]), 64'h0);

    run("b2b", mk(6'd0, 5'd0, 6'b100010), 64'd5, 64'd5,
        1'b1, mk(6'd0, 5'd0, 6'b101010), '1, 64'd1);
    check("b2b_lit", obs_c(0), 64'h1);

    run("srlv_busy", mk(6'd0, 5'd0, 6'b000110), 64'hF0F0_1234_5678_9ABC, 64'd8,
        1'b1, mk(6'd0, 5'd0, 6'b100000), 64'd1, 64'd1);

    run("ill_fn", mk(6'd0, 5'd0, 6'b111111), 64'd7, 64'd9, 1'b0, 32'h0, 64'h0, 64'h0);
    check("ill_fn_lit", 64'(ill_o), 64'h7);
    run("and", mk(6'd0, 5'd0, 6'b100100), 64'hFF00, 64'h0FF0, 1'b0, 32'h0, 64'h0, 64'h0);
    check("and_lit", 64'(ill_o), 64'h0);
    run("ill_op", mk(6'h23, 5'd0, 6'b100000), 64'd3, 64'd4, 1'b0, 32'h0, 64'h0, 64'h0);

    run("sllv40", mk(6'd0, 5'd0, 6'b000100), 64'h0000_0001_8000_0003, 64'd40,
        1'b0, 32'h0, 64'h0, 64'h0);
    check("sllv40_lit", obs_c(2), 64'h0000_0300_0000_0000);

    run("sll0", mk(6'd0, 5'd0, 6'b000000), 64'hDEAD_BEEF_8000_0001, 64'd64,
        1'b0, 32'h0, 64'h0, 64'h0);

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : funct_tab[$urandom_range(0, 17)];
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
      run($sformatf("rnd%0d", n), mk(op, 5'($urandom), fn), ra, rb,
          ($urandom_range(0, 3) == 0), mk(6'd0, 5'($urandom), funct_tab[$urandom_range(0, 17)]),
          {$urandom, $urandom}, 64'($urandom_range(0, 70)));
    end

    // Reset in the middle of an srlv by 20: aborted, no done, everything back to zero.
    start = 1'b1; i_datain = mk(6'd0, 5'd0, 6'b000110); gr1 = {$urandom, $urandom};
    gr2 = 64'd20;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid.busy", 64'(busy_o), 64'h7);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    for (int cyc = 0; cyc < 6; cyc++) begin
      for (int d = 0; d < 3; d++) check_dut("rst_mid", d, cyc, 1'b0, 1'b0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
